// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception controller slice:
//   - exc_state_t : controller FSM states
//   - CAUSE_*     : 5-bit encoded exception cause codes
// No ports (package only).
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4
    } exc_state_t;

    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_RI   = 5'd10;
    localparam logic [4:0] CAUSE_OV   = 5'd12;
    localparam logic [4:0] CAUSE_WR0  = 5'd14;
    localparam logic [4:0] CAUSE_DZ   = 5'd15;
    localparam logic [4:0] CAUSE_UNK  = 5'd31;

endpackage

// File: rtl/exc_cause_enc.sv
// -----------------------------------------------------------------------------
// exc_cause_enc
// Purely combinational fixed-priority encoder turning the five individual
// exception cause lines into a 5-bit cause code.
// Priority (high -> low): invalid_addr, control, overflow, div_zero, write2_0.
// No cause asserted yields CAUSE_UNK.
// Ports:
//   invalid_addr, control, overflow, div_zero, write2_0 : in  1  cause lines
//   code                                                : out 5  encoded cause
// -----------------------------------------------------------------------------
module exc_cause_enc
    import exc_pkg::*;
(
    input  logic       invalid_addr,
    input  logic       control,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       write2_0,
    output logic [4:0] code
);

    // Priority selection of the highest-ranked asserted cause.
    always_comb begin
        code = CAUSE_UNK;
        if (invalid_addr) begin
            code = CAUSE_ADEL;
        end else if (control) begin
            code = CAUSE_RI;
        end else if (overflow) begin
            code = CAUSE_OV;
        end else if (div_zero) begin
            code = CAUSE_DZ;
        end else if (write2_0) begin
            code = CAUSE_WR0;
        end else begin
            code = CAUSE_UNK;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
// Sequential exception controller. Samples the detector summary flag and the
// cause lines, latches EPC and an encoded cause, then steps through
// FLUSH -> REDIRECT -> HANDLER, and returns the fetch PC to EPC on ERET.
// All outputs are registered; nothing combinational reaches an output.
//
// Optional feature (macro EXC_COUNT_EN):
//   exc_count   out 16  serviced exceptions, saturating at 16'hFFFF
//   exc_dropped out 1   sticky: EH_flag seen while not in IDLE
//
// Parameters: PC_W (PC width), HANDLER_ADDR (handler entry PC)
// Ports:
//   clk, rst (sync active-high)                          in
//   EH_flag, EH_overflow, EH_Invalid_addr, EH_Div_zero,
//   EH_control, EH_write2_0                              in  1 each
//   exc_pc                                               in  PC_W
//   eret                                                 in  1
//   flush, pc_redirect, in_handler                       out 1
//   pc_target, epc                                       out PC_W
//   cause                                                out 5
// -----------------------------------------------------------------------------
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_ADDR = 32'h0000_0080
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            EH_flag,
    input  logic            EH_overflow,
    input  logic            EH_Invalid_addr,
    input  logic            EH_Div_zero,
    input  logic            EH_control,
    input  logic            EH_write2_0,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            eret,
    output logic            flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] epc,
    output logic [4:0]      cause,
    output logic            in_handler
`ifdef EXC_COUNT_EN
    ,
    output logic [15:0]     exc_count,
    output logic            exc_dropped
`endif
);

    exc_state_t state_r;
    logic [4:0] enc_cause_s;

    exc_cause_enc u_enc (
        .invalid_addr (EH_Invalid_addr),
        .control      (EH_control),
        .overflow     (EH_overflow),
        .div_zero     (EH_Div_zero),
        .write2_0     (EH_write2_0),
        .code         (enc_cause_s)
    );

    // Controller FSM; outputs are loaded with the decode of the next state so
    // they are registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            epc         <= '0;
            cause       <= 5'd0;
            in_handler  <= 1'b0;
        end else begin
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            in_handler  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (EH_flag) begin
                        state_r <= FLUSH;
                        epc     <= exc_pc;
                        cause   <= enc_cause_s;
                        flush   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FLUSH: begin
                    state_r     <= REDIRECT;
                    flush       <= 1'b1;
                    pc_redirect <= 1'b1;
                    pc_target   <= HANDLER_ADDR;
                end
                REDIRECT: begin
                    state_r    <= HANDLER;
                    in_handler <= 1'b1;
                end
                HANDLER: begin
                    // EH_flag is masked here; eret alone decides the exit.
                    if (eret) begin
                        state_r     <= RETURN;
                        flush       <= 1'b1;
                        pc_redirect <= 1'b1;
                        pc_target   <= epc;
                        in_handler  <= 1'b1;
                    end else begin
                        state_r    <= HANDLER;
                        in_handler <= 1'b1;
                    end
                end
                RETURN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    // Serviced-exception counter and sticky dropped-exception flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count   <= 16'd0;
            exc_dropped <= 1'b0;
        end else begin
            if ((state_r == IDLE) && EH_flag && (exc_count != 16'hFFFF)) begin
                exc_count <= exc_count + 16'd1;
            end else begin
                exc_count <= exc_count;
            end
            if ((state_r != IDLE) && EH_flag) begin
                exc_dropped <= 1'b1;
            end else begin
                exc_dropped <= exc_dropped;
            end
        end
    end
`else
    // Counter feature not built: no extra ports or state.
`endif

endmodule
